// File: rtl/nios2_ocimem_arbiter_if.sv
// CPU-side Avalon-MM bus into the OCI RAM arbiter.
// The CPU data master drives requests; the arbiter returns stall and read data.
interface nios2_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata
    );
endinterface

// File: rtl/nios2_ocimem_arbiter.sv
// Shares one single-port OCI RAM between the CPU Avalon slave and JTAG debug
// strobes, with a one-deep JTAG request buffer and round-robin arbitration.
module nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    input  logic                      take_no_action_ocimem_a,
    input  logic [37:0]               jdo,
    nios2_ocimem_arbiter_if.slave     avs,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_we,
    output logic [3:0]                ram_be,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata,
    output logic [31:0]               MonDReg,
    output logic                      jtag_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } state_t;

    typedef enum logic { PEND_RD = 1'b0, PEND_WR = 1'b1 } pend_kind_t;
    typedef enum logic { LG_CPU  = 1'b0, LG_JTAG = 1'b1 } grant_src_t;

    state_t            state_q,      state_d;
    logic              pend_valid_q, pend_valid_d;
    pend_kind_t        pend_kind_q,  pend_kind_d;
    logic [31:0]       pend_wdata_q, pend_wdata_d;
    logic [ADDR_W-1:0] jaddr_q,      jaddr_d;
    grant_src_t        last_q,       last_d;
    logic [31:0]       mon_q,        mon_d;
    logic              overrun_q,    overrun_d;
    logic              skip_inc_q,   skip_inc_d;

    logic cpu_req;
    logic grant_jtag;
    logic grant_cpu;
    logic queue_req;
    logic queue_accept;
    logic load_addr;
    logic unused_jdo;

    assign cpu_req = avs.avs_read | avs.avs_write;

    // JTAG wins in IDLE unless the CPU is waiting and JTAG had the last turn.
    assign grant_jtag = (state_q == IDLE) && pend_valid_q && (!cpu_req || (last_q == LG_CPU));
    assign grant_cpu  = (state_q == IDLE) && !grant_jtag && cpu_req;

    // A slot frees up in the same cycle its occupant is granted.
    assign queue_req    = (take_action_ocimem_a && jdo[35]) || take_action_ocimem_b
                          || take_no_action_ocimem_a;
    assign queue_accept = !pend_valid_q || grant_jtag;
    assign load_addr    = take_action_ocimem_a && (!jdo[35] || queue_accept);

    assign unused_jdo = ^jdo[37:36];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d         = state_q;
        pend_valid_d    = pend_valid_q;
        pend_kind_d     = pend_kind_q;
        pend_wdata_d    = pend_wdata_q;
        jaddr_d         = jaddr_q;
        last_d          = last_q;
        mon_d           = mon_q;
        overrun_d       = overrun_q;
        skip_inc_d      = 1'b0;
        ram_addr        = jaddr_q;
        ram_we          = 1'b0;
        ram_be          = 4'h0;
        ram_wdata       = 32'h0;
        avs.avs_waitrequest = 1'b1;
        avs.avs_readdata    = 32'h0;

        case (state_q)
            IDLE: begin
                if (grant_jtag) begin
                    last_d       = LG_JTAG;
                    pend_valid_d = 1'b0;
                    ram_addr     = jaddr_q;
                    if (pend_kind_q == PEND_WR) begin
                        ram_we    = 1'b1;
                        ram_be    = 4'hF;
                        ram_wdata = pend_wdata_q;
                        jaddr_d   = jaddr_q + ADDR_W'(1);
                    end else begin
                        state_d = J_RD;
                    end
                end else if (grant_cpu) begin
                    last_d   = LG_CPU;
                    ram_addr = avs.avs_address;
                    if (avs.avs_write) begin
                        ram_we              = 1'b1;
                        ram_be              = avs.avs_byteenable;
                        ram_wdata           = avs.avs_writedata;
                        avs.avs_waitrequest = 1'b0;
                    end else begin
                        state_d = C_RD;
                    end
                end
            end
            J_RD: begin
                mon_d   = ram_rdata;
                state_d = IDLE;
                // The address was reloaded while this read was being granted; keep it.
                if (!skip_inc_q) begin
                    jaddr_d = jaddr_q + ADDR_W'(1);
                end
            end
            C_RD: begin
                avs.avs_readdata    = ram_rdata;
                avs.avs_waitrequest = 1'b0;
                state_d             = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (queue_req) begin
            if (queue_accept) begin
                pend_valid_d = 1'b1;
                if (take_action_ocimem_b) begin
                    pend_kind_d  = PEND_WR;
                    pend_wdata_d = jdo[34:3];
                end else begin
                    pend_kind_d  = PEND_RD;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end

        // A fresh JTAG address overrides any post-access increment in the same cycle.
        if (load_addr) begin
            jaddr_d    = jdo[ADDR_W-1:0];
            skip_inc_d = grant_jtag && (pend_kind_q == PEND_RD);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_kind_q  <= PEND_RD;
            pend_wdata_q <= 32'h0;
            jaddr_q      <= '0;
            last_q       <= LG_CPU;
            mon_q        <= 32'h0;
            overrun_q    <= 1'b0;
            skip_inc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_kind_q  <= pend_kind_d;
            pend_wdata_q <= pend_wdata_d;
            jaddr_q      <= jaddr_d;
            last_q       <= last_d;
            mon_q        <= mon_d;
            overrun_q    <= overrun_d;
            skip_inc_q   <= skip_inc_d;
        end
    end

    assign MonDReg      = mon_q;
    assign jtag_overrun = overrun_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter: directed scenarios plus a randomized
// concurrent CPU/JTAG phase checked against a word-level shadow memory.
module tb_nios2_ocimem_arbiter;

    localparam int KA  = 0;
    localparam int KB  = 1;
    localparam int KNA = 2;

    logic        clk;
    logic        reset_n;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        jtag_overrun;

    int tests;
    int fails;

    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    bit          ram_loaded;
    logic [31:0] exp_mon;

    nios2_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

    nios2_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .avs                     (bus),
        .ram_addr                (ram_addr),
        .ram_we                  (ram_we),
        .ram_be                  (ram_be),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input logic [7:0] a);
        return {8'hC3, a, ~a, 8'h5A};
    endfunction

    // Registered-read RAM: data for the address presented in cycle N appears in cycle N+1.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_init(8'(i));
            ram_loaded <= 1'b1;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [37:0] jd_addr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j       = '0;
        j[35]   = rd;
        j[7:0]  = a;
        j[37:36] = 2'($urandom_range(0, 3));
        return j;
    endfunction

    function automatic logic [37:0] jd_data(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    // One-cycle JTAG strobe; returns at the negedge of the following cycle.
    task automatic jtag(input int kind, input logic [37:0] d);
        @(negedge clk);
        jdo                     = d;
        take_action_ocimem_a    = (kind == KA);
        take_action_ocimem_b    = (kind == KB);
        take_no_action_ocimem_a = (kind == KNA);
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo                     = {6'h0, 32'($urandom)};
    endtask

    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int stalls, output logic [31:0] rd,
                          output bit done);
        stalls = 0;
        done   = 1'b0;
        rd     = '0;
        @(negedge clk);
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        bus.avs_byteenable = be;
        bus.avs_read       = !wr;
        bus.avs_write      = wr;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (!bus.avs_waitrequest) begin
                done = 1'b1;
                rd   = bus.avs_readdata;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        @(negedge clk);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    initial begin
        int          stalls;
        logic [31:0] rd;
        bit          done;

        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
        bus.avs_address = '0;
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_byteenable = '0;
        for (int i = 0; i < 256; i++) shadow[i] = mem_init(8'(i));

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_readdata", bus.avs_readdata, 32'h0);
        check("rst_mon", MonDReg, 32'h0);
        check("rst_overrun", jtag_overrun, 1'b0);
        check("rst_jaddr", dut.jaddr_q, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // JTAG write then read-back, no CPU traffic
        jtag(KA, jd_addr(8'h10, 1'b0));
        #1;
        check("addr_only_jaddr", dut.jaddr_q, 8'h10);
        check("addr_only_no_req", ram_we, 1'b0);
        jtag(KB, jd_data(32'hDEADBEEF));
        #1;
        check("jwr_we", ram_we, 1'b1);
        check("jwr_addr", ram_addr, 8'h10);
        check("jwr_be", ram_be, 4'hF);
        check("jwr_data", ram_wdata, 32'hDEADBEEF);
        model_write(8'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        #1;
        check("jwr_jaddr", dut.jaddr_q, 8'h11);
        check("jwr_mem", mem[8'h10], shadow[8'h10]);
        jtag(KA, jd_addr(8'h10, 1'b1));
        #1;
        check("jrd_addr", ram_addr, 8'h10);
        check("jrd_we", ram_we, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("jrd_mon", MonDReg, 32'hDEADBEEF);
        check("jrd_jaddr", dut.jaddr_q, 8'h11);

        // Address wrap on a read
        jtag(KA, jd_addr(8'hFF, 1'b0));
        jtag(KNA, '0);
        #1;
        check("wrap_addr", ram_addr, 8'hFF);
        repeat (2) @(negedge clk);
        #1;
        check("wrap_jaddr", dut.jaddr_q, 8'h00);
        check("wrap_mon", MonDReg, shadow[8'hFF]);

        // Contention: CPU read held, JTAG reads queued, last grant CPU
        cpu_op(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, stalls, rd, done);
        model_write(8'h20, 32'hCAFEF00D, 4'hF);
        check("cwr_done", done, 1'b1);
        check("cwr_stalls", stalls, 0);
        jtag(KA, jd_addr(8'h30, 1'b0));
        jtag(KNA, '0);
        bus.avs_address = 8'h05;
        bus.avs_read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        #1;
        check("cont_g1_jtag", ram_addr, 8'h30);
        check("cont_g1_wait", bus.avs_waitrequest, 1'b1);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        #1;
        check("cont_jrd_wait", bus.avs_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        check("cont_g2_cpu", ram_addr, 8'h05);
        check("cont_g2_wait", bus.avs_waitrequest, 1'b1);
        @(negedge clk);
        #1;
        check("cont_c1_wait", bus.avs_waitrequest, 1'b0);
        check("cont_c1_data", bus.avs_readdata, shadow[8'h05]);
        @(negedge clk);
        bus.avs_address = 8'h06;
        #1;
        check("cont_g3_jtag", ram_addr, 8'h31);
        check("cont_g3_wait", bus.avs_waitrequest, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("cont_g4_cpu", ram_addr, 8'h06);
        @(negedge clk);
        #1;
        check("cont_c2_wait", bus.avs_waitrequest, 1'b0);
        check("cont_c2_data", bus.avs_readdata, shadow[8'h06]);
        @(negedge clk);
        bus.avs_read = 1'b0;
        #1;
        check("cont_mon", MonDReg, shadow[8'h31]);
        check("cont_jaddr", dut.jaddr_q, 8'h32);
        check("cont_no_overrun", jtag_overrun, 1'b0);
        exp_mon = shadow[8'h31];

        // Randomized concurrent phase: CPU in 0x00-0x7F, JTAG in 0x80-0xF9
        fork
            begin : cpu_thr
                bit          wr;
                logic [7:0]  a;
                logic [31:0] d;
                logic [3:0]  be;
                int          st;
                logic [31:0] r;
                bit          ok;
                for (int k = 0; k < 30; k++) begin
                    wr = 1'($urandom_range(0, 1));
                    a  = 8'($urandom_range(0, 127));
                    d  = $urandom;
                    be = 4'($urandom_range(0, 15));
                    cpu_op(wr, a, d, be, st, r, ok);
                    check("rnd_cpu_done", ok, 1'b1);
                    if (wr) begin
                        model_write(a, d, be);
                        check("rnd_cpu_wr_stall", st <= 2, 1'b1);
                    end else begin
                        check("rnd_cpu_rd_data", r, shadow[a]);
                        check("rnd_cpu_rd_stall", (st >= 1) && (st <= 3), 1'b1);
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin : jtag_thr
                logic [7:0]  ja;
                logic [7:0]  na;
                logic [31:0] d;
                int          op;
                ja = 8'($urandom_range(128, 240));
                jtag(KA, jd_addr(ja, 1'b0));
                for (int k = 0; k < 20; k++) begin
                    if (ja > 8'hF8) begin
                        ja = 8'($urandom_range(128, 200));
                        jtag(KA, jd_addr(ja, 1'b0));
                    end
                    op = $urandom_range(0, 2);
                    if (op == 0) begin
                        d = $urandom;
                        jtag(KB, jd_data(d));
                        model_write(ja, d, 4'hF);
                        ja = ja + 8'd1;
                    end else if (op == 1) begin
                        jtag(KNA, '0);
                        exp_mon = shadow[ja];
                        ja = ja + 8'd1;
                    end else begin
                        na = 8'($urandom_range(128, 240));
                        jtag(KA, jd_addr(na, 1'b1));
                        exp_mon = shadow[na];
                        ja = na + 8'd1;
                    end
                    repeat (6) @(negedge clk);
                    #1;
                    check("rnd_jaddr", dut.jaddr_q, ja);
                    check("rnd_mon", MonDReg, exp_mon);
                end
            end
        join
        #1;
        check("rnd_no_overrun", jtag_overrun, 1'b0);

        // Overrun: second strobe while the CPU owns the RAM
        jtag(KA, jd_addr(8'h50, 1'b0));
        bus.avs_address = 8'h07;
        bus.avs_read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        #1;
        check("ovr_cpu_grant", ram_addr, 8'h07);
        @(negedge clk);
        #1;
        check("ovr_cpu_data", bus.avs_readdata, shadow[8'h07]);
        check("ovr_not_yet", jtag_overrun, 1'b0);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        bus.avs_read = 1'b0;
        #1;
        check("ovr_set", jtag_overrun, 1'b1);
        check("ovr_jtag_grant", ram_addr, 8'h50);
        repeat (4) @(negedge clk);
        #1;
        check("ovr_one_read", dut.jaddr_q, 8'h51);
        check("ovr_mon", MonDReg, shadow[8'h50]);
        cpu_op(1'b0, 8'h08, 32'h0, 4'h0, stalls, rd, done);
        check("ovr_cpu_rd", rd, shadow[8'h08]);
        #1;
        check("ovr_sticky", jtag_overrun, 1'b1);

        // Reset during J_RD with a write queued behind it
        jtag(KNA, '0);
        take_action_ocimem_b = 1'b1;
        jdo = jd_data(32'hA5A5A5A5);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rrd_mon", MonDReg, 32'h0);
        check("rrd_jaddr", dut.jaddr_q, 8'h00);
        check("rrd_overrun", jtag_overrun, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rrd_pending_dropped", dut.jaddr_q, 8'h00);
        check("rrd_mem0", mem[8'h00], shadow[8'h00]);
        check("rrd_mon_after", MonDReg, 32'h0);
        @(negedge clk);
        bus.avs_address = 8'h40;
        bus.avs_writedata = 32'h12345678;
        bus.avs_byteenable = 4'b0011;
        bus.avs_write = 1'b1;
        #1;
        check("rcw_wait", bus.avs_waitrequest, 1'b0);
        check("rcw_we", ram_we, 1'b1);
        check("rcw_be", ram_be, 4'b0011);
        check("rcw_addr", ram_addr, 8'h40);
        check("rcw_data", ram_wdata, 32'h12345678);
        model_write(8'h40, 32'h12345678, 4'b0011);
        @(negedge clk);
        bus.avs_write = 1'b0;
        #1;
        check("rcw_mem", mem[8'h40], shadow[8'h40]);
        check("rcw_idle_we", ram_we, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nios2_ocimem_arbiter.md
NIOS2_OCIMEM_ARBITER -- requirements
Module: nios2_ocimem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, OCI RAM word-address width.
REQ-002 clk  in  1  single clock domain for all logic.
REQ-003 reset_n  in  1  asynchronous assert, active-low reset.
REQ-004 take_action_ocimem_a  in  1  JTAG strobe: load address from jdo[ADDR_W-1:0]; if jdo[35]=1, also queue a read.
REQ-005 take_action_ocimem_b  in  1  JTAG strobe: queue a write of jdo[34:3] at the current JTAG address.
REQ-006 take_no_action_ocimem_a  in  1  JTAG strobe: queue a read at the current JTAG address.
REQ-007 jdo  in  38  JTAG data, sampled only on a strobe cycle.
REQ-008 avs_address  in  ADDR_W  CPU word address.
REQ-009 avs_read, avs_write  in  1 each  CPU request; never both high together.
REQ-010 avs_writedata  in  32  CPU write data.
REQ-011 avs_byteenable  in  4  CPU byte enables.
REQ-012 avs_waitrequest  out  1  CPU stall.
REQ-013 avs_readdata  out  32  CPU read data.
REQ-014 ram_addr  out  ADDR_W  RAM address.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_be  out  4  RAM byte enables.
REQ-017 ram_wdata  out  32  RAM write data.
REQ-018 ram_rdata  in  32  RAM read data, registered, valid one cycle after the address.
REQ-019 MonDReg  out  32  last JTAG read data.
REQ-020 jtag_overrun  out  1  sticky flag: a JTAG strobe was dropped.

Function
REQ-021 FSM states: IDLE, J_RD, C_RD; RAM port is combinational from state and grant.
REQ-022 JTAG strobes SHALL load a one-deep pending register {kind, wdata}; only one strobe is high in any cycle.
REQ-023 A strobe arriving while pending is set and not being granted that cycle SHALL be dropped and SHALL set jtag_overrun.
REQ-024 A strobe in the same cycle as a pending grant SHALL be accepted into pending with no overrun.
REQ-025 IDLE arbitration: grant JTAG if pending and (no CPU request or last_grant=CPU); else grant CPU if a CPU request is present.
REQ-026 last_grant SHALL update on every grant; this gives round-robin under contention.
REQ-027 JTAG write grant: ram_addr=jaddr, ram_we=1, ram_be=4'hF, ram_wdata=pending data; clear pending; jaddr+1; stay in IDLE.
REQ-028 JTAG read grant: ram_addr=jaddr, ram_we=0; clear pending; go to J_RD.
REQ-029 J_RD: MonDReg<=ram_rdata; jaddr+1; return to IDLE. No grant is made in J_RD.
REQ-030 CPU write grant: ram_addr=avs_address, ram_we=1, ram_be=avs_byteenable, ram_wdata=avs_writedata; avs_waitrequest=0 that cycle.
REQ-031 CPU read grant: avs_waitrequest=1, go to C_RD.
REQ-032 C_RD: avs_readdata=ram_rdata, avs_waitrequest=0; return to IDLE.
REQ-033 avs_waitrequest=1 whenever a CPU request is not being completed; minimum CPU latency: write 0 stall cycles, read 1 stall cycle.
REQ-034 An address-only ocimem_a (jdo[35]=0) SHALL update jaddr in the strobe cycle and SHALL NOT queue a request.
REQ-035 jaddr increments wrap from 2^ADDR_W-1 to 0.
REQ-036 ram_we=0 in every cycle without a write grant.

Reset
REQ-037 On reset_n low: state=IDLE, pending=0, jaddr=0, last_grant=CPU, MonDReg=0, jtag_overrun=0, avs_readdata=0, ram_we=0.
REQ-038 Reset mid-operation SHALL abandon any in-flight read without updating MonDReg and SHALL drop any queued request.
REQ-039 jtag_overrun SHALL clear only on reset.

Verification
REQ-040 JTAG write/read, no CPU traffic: ocimem_a with jdo[7:0]=0x10, jdo[35]=0; then ocimem_b with data 0xDEADBEEF -> RAM[0x10] written, jaddr=0x11. Then ocimem_a with addr 0x10, jdo[35]=1 -> MonDReg=0xDEADBEEF 2 cycles later, jaddr=0x11.
REQ-041 Contention: CPU read held continuously with JTAG read pending, last_grant=CPU -> JTAG granted first; CPU completes next; grants alternate over 4 requests.
REQ-042 Overrun: two JTAG strobes while the CPU holds the grant -> second strobe dropped, jtag_overrun=1 and stays 1 until reset.
REQ-043 Wrap: jaddr=0xFF, no_action_ocimem_a -> read of 0xFF, jaddr=0x00.
REQ-044 Reset during J_RD -> MonDReg=0, state IDLE, pending=0; a subsequent CPU write 0x12345678 with byteenable 4'b0011 completes with 0 stalls, RAM written with ram_be=4'b0011.
